// File: rtl/pll_clk_gen_pkg.sv
// pll_clk_gen_pkg: shared constants and helpers for the behavioural PLL stand-in.
//   CLKOUT1_DIVIDE_DEF / CLKOUT2_DIVIDE_DEF / LOCK_CYCLES_DEF : default parameters
//   MAX_DIVIDE / MAX_LOCK : upper legal parameter limits
//   cnt_width(n)          : counter width for a modulo-n counter, max(1, clog2(n))
package pll_clk_gen_pkg;

  localparam int unsigned CLKOUT1_DIVIDE_DEF = 2;
  localparam int unsigned CLKOUT2_DIVIDE_DEF = 4;
  localparam int unsigned LOCK_CYCLES_DEF    = 16;

  localparam int unsigned MAX_DIVIDE = 256;
  localparam int unsigned MAX_LOCK   = 65535;

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pll_div_gen.sv
// pll_div_gen: registered clock divider with a floor(DIVIDE/2)-high duty cycle.
// Ports:
//   clk_in1 : reference clock
//   reset   : synchronous, active-high reset
//   en      : lock state being loaded on this edge (the next value of locked)
//   clk_div : divided clock, 0 while not enabled
module pll_div_gen
  import pll_clk_gen_pkg::*;
#(
  parameter int unsigned DIVIDE = CLKOUT1_DIVIDE_DEF
) (
  input  logic clk_in1,
  input  logic reset,
  input  logic en,
  output logic clk_div
);

  localparam int unsigned     W    = cnt_width(DIVIDE);
  localparam logic [W-1:0]    LAST = W'(DIVIDE - 1);
  localparam logic [W-1:0]    HALF = W'(DIVIDE / 2);

  if (DIVIDE < 2 || DIVIDE > MAX_DIVIDE) begin : g_bad_divide
    $error("pll_div_gen: DIVIDE=%0d outside 2..%0d", DIVIDE, MAX_DIVIDE);
  end

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  logic         running;

  // en is the lock value being registered this edge, so on the locking edge
  // the counter is still held at 0 and clk_div rises together with locked.
  // running mirrors the registered locked and lets the counter advance after.
  always_comb begin
    cnt_next = '0;
    if (running)
      cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk_in1) begin
    if (reset || !en) begin
      cnt     <= '0;
      running <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      running <= 1'b1;
      clk_div <= (cnt_next < HALF);
    end
  end

endmodule

// File: rtl/pll_clk_gen.sv
// pll_clk_gen: synthesizable behavioural stand-in for the vendor clock-wizard PLL.
// Optional feature macro: PLL_CLK_OUT2_EN (adds clk_out2 and a second divider).
// Ports:
//   clk_in1  : reference clock, the only clock
//   reset    : synchronous, active-high reset
//   clk_out1 : clk_in1 divided by CLKOUT1_DIVIDE, registered
//   locked   : high LOCK_CYCLES edges after reset release, sticky until reset
//   clk_out2 : clk_in1 divided by CLKOUT2_DIVIDE (PLL_CLK_OUT2_EN only)
module pll_clk_gen
  import pll_clk_gen_pkg::*;
#(
  parameter int unsigned CLKOUT1_DIVIDE = CLKOUT1_DIVIDE_DEF,
  parameter int unsigned CLKOUT2_DIVIDE = CLKOUT2_DIVIDE_DEF,
  parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF
) (
  input  logic clk_in1,
  input  logic reset,
  output logic clk_out1,
  output logic locked
`ifdef PLL_CLK_OUT2_EN
  ,
  output logic clk_out2
`endif
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  if (LOCK_CYCLES < 1 || LOCK_CYCLES > MAX_LOCK) begin : g_bad_lock
    $error("pll_clk_gen: LOCK_CYCLES=%0d outside 1..%0d", LOCK_CYCLES, MAX_LOCK);
  end

  logic [LW-1:0] lock_cnt;
  logic          lock_next;

  // Reset wins over a lock that would otherwise land on the same edge.
  always_comb begin
    lock_next = 1'b0;
    if (!reset)
      lock_next = locked || (lock_cnt == LW'(LOCK_CYCLES - 1));
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (lock_cnt != LW'(LOCK_CYCLES))
        lock_cnt <= lock_cnt + 1'b1;
      locked <= lock_next;
    end
  end

  pll_div_gen #(
    .DIVIDE (CLKOUT1_DIVIDE)
  ) u_div1 (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .en      (lock_next),
    .clk_div (clk_out1)
  );

`ifdef PLL_CLK_OUT2_EN
  pll_div_gen #(
    .DIVIDE (CLKOUT2_DIVIDE)
  ) u_div2 (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .en      (lock_next),
    .clk_div (clk_out2)
  );
`endif

endmodule

// File: tb/tb_pll_clk_gen.sv
// tb_pll_clk_gen: scoreboard bench for pll_clk_gen. Three instances share one
// reset: defaults (D=2, L=16), D=5/L=4 and D=2/L=1. The stimulus process drives
// reset each cycle and queues the expected outputs of every instance; a
// monitor pops and compares one entry per clock edge.
module tb_pll_clk_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_clk, a_lock, b_clk, b_lock, c_clk, c_lock;
`ifdef PLL_CLK_OUT2_EN
  logic a_clk2, b_clk2, c_clk2;
`endif

  always #5 clk = ~clk;

  pll_clk_gen u_def (
    .clk_in1  (clk),
    .reset    (rst),
    .clk_out1 (a_clk),
    .locked   (a_lock)
`ifdef PLL_CLK_OUT2_EN
    ,
    .clk_out2 (a_clk2)
`endif
  );

  pll_clk_gen #(
    .CLKOUT1_DIVIDE (5),
    .LOCK_CYCLES    (4)
  ) u_d5 (
    .clk_in1  (clk),
    .reset    (rst),
    .clk_out1 (b_clk),
    .locked   (b_lock)
`ifdef PLL_CLK_OUT2_EN
    ,
    .clk_out2 (b_clk2)
`endif
  );

  pll_clk_gen #(
    .CLKOUT1_DIVIDE (2),
    .LOCK_CYCLES    (1)
  ) u_l1 (
    .clk_in1  (clk),
    .reset    (rst),
    .clk_out1 (c_clk),
    .locked   (c_lock)
`ifdef PLL_CLK_OUT2_EN
    ,
    .clk_out2 (c_clk2)
`endif
  );

  typedef struct packed {
    logic a_lock, a_clk, a_clk2;
    logic b_lock, b_clk, b_clk2;
    logic c_lock, c_clk, c_clk2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;
  int   since    = 0;

  // Edge k after release (k = 1, 2, ...): locked once k >= L, and the divided
  // clock is high for the first floor(D/2) edges of each D-edge period
  // starting at the locking edge.
  function automatic logic exp_lock(input int k, input int l);
    return (k >= l);
  endfunction

  function automatic logic exp_div(input int k, input int l, input int d);
    if (k < l) return 1'b0;
    return (((k - l) % d) < (d / 2));
  endfunction

  task automatic check(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, got, want);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (r) since = 0;
    else   since = since + 1;
    e.a_lock = exp_lock(since, 16);
    e.a_clk  = exp_div(since, 16, 2);
    e.a_clk2 = exp_div(since, 16, 4);
    e.b_lock = exp_lock(since, 4);
    e.b_clk  = exp_div(since, 4, 5);
    e.b_clk2 = exp_div(since, 4, 4);
    e.c_lock = exp_lock(since, 1);
    e.c_clk  = exp_div(since, 1, 2);
    e.c_clk2 = exp_div(since, 1, 4);
    exp_q.push_back(e);
  endtask

  task automatic run(input logic r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Monitor: every edge presents a new output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        edge_no++;
        e = exp_q.pop_front();
        check("def_locked", a_lock, e.a_lock);
        check("def_clk_out1", a_clk, e.a_clk);
        check("d5_locked", b_lock, e.b_lock);
        check("d5_clk_out1", b_clk, e.b_clk);
        check("l1_locked", c_lock, e.c_lock);
        check("l1_clk_out1", c_clk, e.c_clk);
`ifdef PLL_CLK_OUT2_EN
        check("def_clk_out2", a_clk2, e.a_clk2);
        check("d5_clk_out2", b_clk2, e.b_clk2);
        check("l1_clk_out2", c_clk2, e.c_clk2);
`endif
      end
    end
  end

  initial begin
    run(1'b1, 3);     // reset state
    run(1'b0, 120);   // lock at 16 / 4 / 1, 20+ periods of D=5
    run(1'b1, 1);     // mid-operation reset pulse
    run(1'b0, 3);
    run(1'b1, 1);     // reset on the edge the L=4 instance would lock
    run(1'b0, 40);    // full lock interval repeats
    run(1'b1, 100);   // long reset: everything stays 0
    run(1'b0, 30);
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
